// File: rtl/uart_frame_rx.sv
// UART frame receiver: 16x oversampling, majority vote over samples 6..11,
// optional parity, 1 or 2 checked stop bits, break detection.
module uart_frame_rx #(
   parameter int DIV       = 325,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

   state_t               state, state_d;
   logic                 rx_meta, rx_s, rx_prev;
   logic [2:0]           warm;
   logic [15:0]          div_cnt;
   logic [3:0]           idx;
   logic [2:0]           vote, vote_nxt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, stop0, ferr_acc;
   logic                 tick, at_mid, at_end, bit_val, fall, done, first_stop;

   // warm[2] only rises once rx_prev holds a value that really came from the pin,
   // so a line held low across reset release cannot look like a falling edge
   assign fall       = warm[2] && rx_prev && !rx_s;
   assign tick       = (state != ST_IDLE) && (div_cnt == 16'(DIV - 1));
   assign at_mid     = tick && (idx == 4'd11);
   assign at_end     = tick && (idx == 4'd15);
   assign vote_nxt   = vote + {2'b00, rx_s};
   assign bit_val    = (vote_nxt >= 3'd4);
   assign first_stop = (bit_cnt == 4'd0) ? bit_val : stop0;
   assign busy       = (state != ST_IDLE);

   always_comb begin
      state_d = state;
      done    = 1'b0;
      case (state)
         ST_IDLE:  if (fall) state_d = ST_START;
         ST_START: begin
            if (at_mid && vote_nxt >= 3'd3) state_d = ST_IDLE;
            else if (at_end)                state_d = ST_DATA;
         end
         ST_DATA:  if (at_end && bit_cnt == 4'(DATA_BITS))
                      state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
         ST_PAR:   if (at_end) state_d = ST_STOP;
         ST_STOP:  if (at_mid && bit_cnt == 4'(STOP_BITS - 1)) begin
                      state_d = ST_IDLE;
                      done    = 1'b1;
                   end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         rx_prev    <= 1'b1;
         warm       <= '0;
         div_cnt    <= '0;
         idx        <= '0;
         vote       <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         stop0      <= 1'b0;
         ferr_acc   <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         warm    <= {warm[1:0], 1'b1};
         valid   <= 1'b0;

         if (state == ST_IDLE) begin
            div_cnt  <= '0;
            idx      <= '0;
            vote     <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
         end else begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick) begin
               idx <= idx + 4'd1;
               if (idx == 4'd0)                     vote <= '0;
               else if (idx >= 4'd6 && idx <= 4'd11) vote <= vote_nxt;
            end
         end

         if (state == ST_DATA && at_mid) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (state == ST_PAR && at_mid) par_bit <= bit_val;
         // bit_cnt is reused as the stop-bit index once the data bits are in
         if (at_end && state_d != state) bit_cnt <= '0;
         if (state == ST_STOP && at_end)  bit_cnt <= bit_cnt + 4'd1;
         if (state == ST_STOP && at_mid) begin
            if (!bit_val)          ferr_acc <= 1'b1;
            if (bit_cnt == 4'd0)   stop0    <= bit_val;
         end

         if (done) begin
            valid      <= 1'b1;
            data       <= shreg;
            parity_err <= (PARITY != 0) && ((^shreg ^ par_bit) != (PARITY == 1));
            frame_err  <= ferr_acc | !bit_val;
            break_det  <= (shreg == '0) && (PARITY == 0 || !par_bit) && !first_stop;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboarded bench for uart_frame_rx: four configurations (8N1, 8E1, 8O1, 7N2)
// at DIV=4, directed corner frames then randomized traffic against a frame model.
module tb_uart_frame_rx;

   localparam int NDUT = 4;
   localparam int BP   = 64;  // clk per bit: 16 ticks * DIV
   localparam int DBS  [NDUT] = '{8, 8, 8, 7};
   localparam int PARS [NDUT] = '{0, 2, 1, 0};
   localparam int SBS  [NDUT] = '{1, 1, 1, 2};

   typedef struct {
      int         idx;
      logic [8:0] data;
      bit         pe, fe, bk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line [NDUT];
   logic [8:0] dout [NDUT];
   logic       vld  [NDUT];
   logic       pe   [NDUT];
   logic       fe   [NDUT];
   logic       bk   [NDUT];
   logic       bsy  [NDUT];

   exp_t       sbq[$];
   logic [8:0] last_data [NDUT];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic [DBS[g]-1:0] d;
      uart_frame_rx #(.DIV(4), .DATA_BITS(DBS[g]), .PARITY(PARS[g]), .STOP_BITS(SBS[g])) u_dut (
         .clk(clk), .rst(rst), .uart_rx(line[g]), .data(d), .valid(vld[g]),
         .parity_err(pe[g]), .frame_err(fe[g]), .break_det(bk[g]), .busy(bsy[g]));
      assign dout[g] = 9'(d);
   end

   // Frame outcome from the line levels: count ones for parity, any low stop
   // bit is a framing error, all-zero through the first stop bit is a break.
   function automatic exp_t model(int i, logic [8:0] d, bit p, bit s0, bit s1);
      exp_t e;
      int   ones;
      e.idx  = i;
      e.data = d & 9'((1 << DBS[i]) - 1);
      ones   = $countones(e.data) + int'(p);
      e.pe   = (PARS[i] == 1) ? (ones % 2 == 0) : (PARS[i] == 2) ? (ones % 2 == 1) : 1'b0;
      e.fe   = !s0 || (SBS[i] == 2 && !s1);
      e.bk   = (e.data == 0) && (PARS[i] == 0 || !p) && !s0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic hold_bit(input int i, input logic v, input int n);
      line[i] = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int i, input logic [8:0] d, input bit p, input bit s0,
                       input bit s1, input int gap);
      sbq.push_back(model(i, d, p, s0, s1));
      hold_bit(i, 1'b0, BP);
      for (int b = 0; b < DBS[i]; b++) hold_bit(i, d[b], BP);
      if (PARS[i] != 0) hold_bit(i, p, BP);
      hold_bit(i, s0, BP);
      if (SBS[i] == 2) hold_bit(i, s1, BP);
      if (gap > 0) hold_bit(i, 1'b1, gap);
   endtask

   task automatic pulse_reset();
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NDUT; i++) last_data[i] = '0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NDUT; i++) begin
         if (vld[i]) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid dut%0d data=%0h pe=%b fe=%b bk=%b",
                        i, dout[i], pe[i], fe[i], bk[i]);
            end else begin
               e = sbq.pop_front();
               last_data[i] = e.data;
               if (e.idx != i || dout[i] !== e.data || pe[i] !== e.pe ||
                   fe[i] !== e.fe || bk[i] !== e.bk) begin
                  errors++;
                  $display("FAIL frame dut%0d data=%0h pe=%b fe=%b bk=%b expected dut%0d data=%0h pe=%b fe=%b bk=%b",
                           i, dout[i], pe[i], fe[i], bk[i], e.idx, e.data, e.pe, e.fe, e.bk);
               end
            end
         end
      end
   end

   initial begin
      logic [8:0] d;
      bit         p, s0, s1;
      int         gap;
      for (int i = 0; i < NDUT; i++) begin
         line[i]      = 1'b1;
         last_data[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++)
         chk($sformatf("reset_state_dut%0d", i),
             32'({dout[i], vld[i], pe[i], fe[i], bk[i], bsy[i]}), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // line held low across reset release must not start a frame
      for (int i = 0; i < NDUT; i++) line[i] = 1'b0;
      pulse_reset();
      repeat (300) @(negedge clk);
      for (int i = 0; i < NDUT; i++)
         chk($sformatf("low_through_reset_busy_dut%0d", i), 32'(bsy[i]), 32'd0);
      for (int i = 0; i < NDUT; i++) line[i] = 1'b1;
      repeat (BP) @(negedge clk);

      send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, BP);
      chk("8n1_busy_after", 32'(bsy[0]), 32'd0);
      send(1, 9'h003, 1'b1, 1'b1, 1'b1, BP);
      send(3, 9'h055, 1'b0, 1'b1, 1'b0, BP);

      // 32-clk low glitch is a false start
      line[0] = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_busy_high", 32'(bsy[0]), 32'd1);
      repeat (22) @(negedge clk);
      line[0] = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_busy_low", 32'(bsy[0]), 32'd0);

      // 12 bit periods low: one break frame, then nothing until the line rises and falls
      sbq.push_back(model(0, 9'h000, 1'b0, 1'b0, 1'b0));
      hold_bit(0, 1'b0, 12 * BP);
      hold_bit(0, 1'b1, 2 * BP);
      chk("break_single_frame", 32'(sbq.size()), 32'd0);
      chk("break_busy_low", 32'(bsy[0]), 32'd0);

      // reset in the middle of data bit 4, then two back-to-back frames
      d = 9'h03C;
      hold_bit(0, 1'b0, BP);
      for (int b = 0; b < 4; b++) hold_bit(0, d[b], BP);
      hold_bit(0, d[4], BP / 2);
      chk("midframe_busy", 32'(bsy[0]), 32'd1);
      pulse_reset();
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      chk("abort_data", 32'(dout[0]), 32'd0);
      hold_bit(0, 1'b1, BP);
      send(0, 9'h03C, 1'b0, 1'b1, 1'b1, 0);
      send(0, 9'h03C, 1'b0, 1'b1, 1'b1, BP);

      for (int i = 0; i < NDUT; i++) begin
         for (int n = 0; n < 12; n++) begin
            d  = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
            p  = 1'($urandom);
            s0 = ($urandom_range(0, 5) != 0);
            s1 = ($urandom_range(0, 5) != 0);
            if ((SBS[i] == 1 && !s0) || (SBS[i] == 2 && !s1))
               gap = BP + int'($urandom_range(0, 40));
            else
               gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 80));
            send(i, d, p, s0, s1, gap);
         end
         repeat (BP) @(negedge clk);
         chk($sformatf("data_hold_dut%0d", i), 32'(dout[i]), 32'(last_data[i]));
         chk($sformatf("idle_busy_dut%0d", i), 32'(bsy[i]), 32'd0);
      end

      repeat (200) @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter DIV, default 325, meaning the number of clk cycles per oversample tick; legal range is 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame; legal range is 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning the parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits checked; legal values are 1 and 2.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port uart_rx, input, width 1: the asynchronous serial line, idle high.
REQ-008 The block SHALL have port data, output, width DATA_BITS: the last received word, LSB first on the wire.
REQ-009 The block SHALL have port valid, output, width 1: a 1-clk pulse at the end of every completed frame.
REQ-010 The block SHALL have port parity_err, output, width 1: the parity-check result, qualified by valid.
REQ-011 The block SHALL have port frame_err, output, width 1: the stop-bit-check result, qualified by valid.
REQ-012 The block SHALL have port break_det, output, width 1: break detection, qualified by valid.
REQ-013 The block SHALL have port busy, output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL pass uart_rx through a 2-flop synchroniser whose reset value is 1; all sampling uses the second flop, rx_s.
REQ-015 A falling edge (previous rx_s=1, current rx_s=0) detected in IDLE SHALL move the FSM to START and clear the tick divider and the sample index.
REQ-016 In non-IDLE states, the tick divider SHALL count 0..DIV-1 and emit a 1-clk tick when it wraps; in IDLE it SHALL be held at 0.
REQ-017 Each bit period SHALL span 16 ticks; a 4-bit sample index 0..15 SHALL advance on each tick and wrap to 0 at the bit boundary.
REQ-018 On ticks with sample index 6..11, a 3-bit vote counter SHALL add rx_s; the bit value SHALL be 1 if the count is at least 4, otherwise 0.
REQ-019 The vote counter SHALL clear at sample index 0 of every bit.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 In START, at index 11, a count of 3 or more SHALL be treated as a false start: the FSM returns to IDLE with no valid pulse; otherwise the FSM proceeds to DATA at the bit boundary.
REQ-022 In DATA, each bit value SHALL be shifted in LSB first; after DATA_BITS bits the FSM SHALL go to PARITY if PARITY is nonzero, else to STOP.
REQ-023 In PARITY, the sampled bit SHALL be checked: with odd parity, the XOR of the data and parity bits must be 1; with even parity, it must be 0; a mismatch SHALL set parity_err.
REQ-024 With PARITY=0, parity_err SHALL always be 0.
REQ-025 In STOP, each stop bit SHALL be evaluated at index 11, and any stop bit with value 0 SHALL set frame_err.
REQ-026 At index 11 of the last stop bit, on the next clk edge the block SHALL load data, parity_err, frame_err and break_det, pulse valid for 1 clk, and return to IDLE without waiting for the remaining ticks.
REQ-027 break_det SHALL be set when all data bits, the parity bit (if present) and the first stop bit are 0; frame_err SHALL also be set in that case.
REQ-028 A falling edge arriving before the return to IDLE SHALL be ignored; a falling edge in the first clk after the return to IDLE SHALL start a new frame.
REQ-029 data and the error flags SHALL hold their values until the next valid pulse.

Reset
REQ-030 When rst is asserted, in any state and mid-frame, the block SHALL immediately force the FSM to IDLE and clear the tick divider, sample index, vote counter and shift register.
REQ-031 Reset SHALL drive data=0, valid=0, parity_err=0, frame_err=0, break_det=0, busy=0, and both synchroniser flops to 1.
REQ-032 After rst is released, the block SHALL start a frame only on a new falling edge; a line held low through reset release SHALL NOT start a frame.

Verification
REQ-033 Scenario (DIV=4, 8N1): send 0xA5 -> exactly one valid pulse, data=0xA5, parity_err=0, frame_err=0, break_det=0, busy low afterwards.
REQ-034 Scenario (DIV=4, 8N1): drive a low glitch of 2 bit periods' worth of ticks... replaced by: drive a low glitch lasting 32 clk (8 ticks), then high -> no valid pulse, busy returns to 0.
REQ-035 Scenario (DIV=4, 8E1): send 0x03 with parity bit 1 -> valid, data=0x03, parity_err=1, frame_err=0.
REQ-036 Scenario (DIV=4, 7N2): send 0x55 with second stop bit 0 -> valid, data=0x55, frame_err=1, break_det=0.
REQ-037 Scenario (DIV=4, 8N1): hold the line low for 12 bit periods -> one valid pulse with data=0x00, frame_err=1, break_det=1, and no further frame until the line rises and falls again.
REQ-038 Scenario (DIV=4, 8N1): assert rst mid-frame at bit 4, then send 0x3C back-to-back twice -> no valid for the aborted frame, then two valid pulses with data=0x3C, both error-free.
